ball_controller: RTL and testbench

//  Sequences the pong ball: serve, per-frame motion, bounces off play-area walls and paddle, miss handling.

---
 rtl/ball_controller_pkg.sv | 14 +
 rtl/ball_controller_if.sv | 28 ++
 rtl/ball_controller_rising_edge_detect.sv | 23 ++
 rtl/ball_controller.sv | 191 +++++++++++++++++++
 tb/tb_ball_controller.sv | 132 +++++++++++++
 5 files changed

// File: rtl/ball_controller_pkg.sv
// Shared definitions for the pong ball controller slice.
//   POSITION_WIDTH : width of every coordinate bus
//   ball_state_t   : externally visible ball sequencing state encoding
package ball_controller_pkg;

   localparam int POSITION_WIDTH = 16;

   typedef enum logic [1:0] {
      BALL_STATE_SERVE = 2'd0,
      BALL_STATE_PLAY  = 2'd1,
      BALL_STATE_MISS  = 2'd2
   } ball_state_t;

endpackage

// File: rtl/ball_controller_if.sv
// Signal bundle between the video top level and the ball controller.
//   master : drives vertical_sync, serve, paddle_x/paddle_y; observes ball outputs
//   slave  : the ball controller itself
interface ball_controller_if;
   import ball_controller_pkg::*;

   logic                      vertical_sync;
   logic                      serve;
   logic [POSITION_WIDTH-1:0] paddle_x;
   logic [POSITION_WIDTH-1:0] paddle_y;
   logic [POSITION_WIDTH-1:0] ball_x;
   logic [POSITION_WIDTH-1:0] ball_y;
   ball_state_t               ball_state;
   logic                      bounce;
   logic [7:0]                hit_count;
   logic [7:0]                miss_count;

   modport master (
      output vertical_sync, serve, paddle_x, paddle_y,
      input  ball_x, ball_y, ball_state, bounce, hit_count, miss_count
   );

   modport slave (
      input  vertical_sync, serve, paddle_x, paddle_y,
      output ball_x, ball_y, ball_state, bounce, hit_count, miss_count
   );

endinterface

// File: rtl/ball_controller_rising_edge_detect.sv
// Rising-edge detector: pulse is high while sig_in is high and was low on the
// previous clock. The history bit resets to 1 so a level that is already high
// when reset releases does not count as an edge.
//   clk, reset : clock and synchronous active-high reset
//   sig_in     : level to watch
//   pulse      : combinational edge indication
module rising_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic pulse
);

   logic sig_prev;

   always_ff @(posedge clk) begin
      if (reset) sig_prev <= 1'b1;
      else       sig_prev <= sig_in;
   end

   assign pulse = sig_in & ~sig_prev;

endmodule

// File: rtl/ball_controller.sv
// Pong ball sequencer: serve, per-frame motion, wall/paddle bounces, misses.
// Advances once per frame on the rising edge of vertical_sync.
//   pixel_clock : sole clock
//   reset       : synchronous, active-high
//   bus         : ball_controller_if.slave (vsync, serve, paddle in; ball out)
//
// state | meaning
// ------+-----------------------------------------------------------
// SERVE | ball parked at start, waiting for serve on a frame tick
// PLAY  | ball moving, bouncing off walls and paddle
// MISS  | ball frozen at left wall for MISS_FRAMES ticks
module ball_controller
   import ball_controller_pkg::*;
#(
   parameter int BALL_RADIUS   = 10,
   parameter int BALL_SPEED_X  = 4,
   parameter int BALL_SPEED_Y  = 3,
   parameter int BALL_START_X  = 640,
   parameter int BALL_START_Y  = 400,
   parameter int X_MIN         = 50,
   parameter int X_MAX         = 1230,
   parameter int Y_MIN         = 50,
   parameter int Y_MAX         = 750,
   parameter int PADDLE_WIDTH  = 20,
   parameter int PADDLE_LENGTH = 200,
   parameter int MISS_FRAMES   = 60
) (
   input logic              pixel_clock,
   input logic              reset,
   ball_controller_if.slave bus
);

   typedef logic [POSITION_WIDTH-1:0] pos_t;
   // One extra bit so sums never wrap and compares stay unsigned-safe.
   typedef logic [POSITION_WIDTH:0]   wide_t;

   localparam int TW = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
   typedef logic [TW-1:0] timer_t;

   localparam wide_t LX     = wide_t'(X_MIN + BALL_RADIUS);
   localparam wide_t HX     = wide_t'(X_MAX - BALL_RADIUS);
   localparam wide_t LY     = wide_t'(Y_MIN + BALL_RADIUS);
   localparam wide_t HY     = wide_t'(Y_MAX - BALL_RADIUS);
   localparam wide_t SX     = wide_t'(BALL_SPEED_X);
   localparam wide_t SY     = wide_t'(BALL_SPEED_Y);
   localparam wide_t RAD    = wide_t'(BALL_RADIUS);
   localparam wide_t PW_R   = wide_t'(PADDLE_WIDTH + BALL_RADIUS);
   localparam wide_t PL_R   = wide_t'(PADDLE_LENGTH + BALL_RADIUS);
   localparam pos_t  START_X = pos_t'(BALL_START_X);
   localparam pos_t  START_Y = pos_t'(BALL_START_Y);
   localparam timer_t TIMER_LAST = timer_t'(MISS_FRAMES - 1);

   ball_state_t state_q, state_next;
   pos_t        x_q, x_next, y_q, y_next;
   logic        dir_x_q, dir_x_next, dir_y_q, dir_y_next;   // 1 = increasing
   logic [7:0]  hit_q, hit_next, miss_q, miss_next;
   timer_t      timer_q, timer_next;
   logic        bounce_q, bounce_next;
   logic        tick;

   wide_t wx, wy, face_x, pad_y;
   logic  paddle_hit;

   rising_edge_detect u_vsync_edge (
      .clk    (pixel_clock),
      .reset  (reset),
      .sig_in (bus.vertical_sync),
      .pulse  (tick)
   );

   assign wx     = {1'b0, x_q};
   assign wy     = {1'b0, y_q};
   assign face_x = {1'b0, bus.paddle_x} + PW_R;
   assign pad_y  = {1'b0, bus.paddle_y};

   assign paddle_hit = (wx >= face_x) && (wx < face_x + SX) &&
                       (wy + RAD >= pad_y) && (wy <= pad_y + PL_R);

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         state_q  <= BALL_STATE_SERVE;
         x_q      <= START_X;
         y_q      <= START_Y;
         dir_x_q  <= 1'b1;
         dir_y_q  <= 1'b1;
         hit_q    <= 8'd0;
         miss_q   <= 8'd0;
         timer_q  <= '0;
         bounce_q <= 1'b0;
      end else begin
         state_q  <= state_next;
         x_q      <= x_next;
         y_q      <= y_next;
         dir_x_q  <= dir_x_next;
         dir_y_q  <= dir_y_next;
         hit_q    <= hit_next;
         miss_q   <= miss_next;
         timer_q  <= timer_next;
         bounce_q <= bounce_next;
      end
   end

   always_comb begin
      state_next  = state_q;
      x_next      = x_q;
      y_next      = y_q;
      dir_x_next  = dir_x_q;
      dir_y_next  = dir_y_q;
      hit_next    = hit_q;
      miss_next   = miss_q;
      timer_next  = timer_q;
      bounce_next = 1'b0;

      if (tick) begin
         unique case (state_q)
            BALL_STATE_SERVE: begin
               x_next = START_X;
               y_next = START_Y;
               if (bus.serve) begin
                  state_next = BALL_STATE_PLAY;
                  dir_x_next = 1'b1;
                  dir_y_next = 1'b1;
               end
            end

            BALL_STATE_PLAY: begin
               if (dir_y_q) begin
                  if (wy + SY > HY) begin
                     y_next      = pos_t'(HY);
                     dir_y_next  = 1'b0;
                     bounce_next = 1'b1;
                  end else begin
                     y_next = pos_t'(wy + SY);
                  end
               end else begin
                  if (wy < LY + SY) begin
                     y_next      = pos_t'(LY);
                     dir_y_next  = 1'b1;
                     bounce_next = 1'b1;
                  end else begin
                     y_next = pos_t'(wy - SY);
                  end
               end

               if (dir_x_q) begin
                  if (wx + SX > HX) begin
                     x_next      = pos_t'(HX);
                     dir_x_next  = 1'b0;
                     bounce_next = 1'b1;
                  end else begin
                     x_next = pos_t'(wx + SX);
                  end
               end else if (paddle_hit) begin
                  x_next      = pos_t'(face_x);
                  dir_x_next  = 1'b1;
                  bounce_next = 1'b1;
                  hit_next    = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
               end else if (wx < LX + SX) begin
                  x_next     = pos_t'(LX);
                  state_next = BALL_STATE_MISS;
                  miss_next  = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
                  timer_next = '0;
               end else begin
                  x_next = pos_t'(wx - SX);
               end
            end

            BALL_STATE_MISS: begin
               if (timer_q == TIMER_LAST) begin
                  state_next = BALL_STATE_SERVE;
                  x_next     = START_X;
                  y_next     = START_Y;
                  timer_next = '0;
               end else begin
                  timer_next = timer_q + timer_t'(1);
               end
            end

            default: state_next = BALL_STATE_SERVE;
         endcase
      end
   end

   assign bus.ball_x     = x_q;
   assign bus.ball_y     = y_q;
   assign bus.ball_state = state_q;
   assign bus.bounce     = bounce_q;
   assign bus.hit_count  = hit_q;
   assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: a table of frame-tick vectors walks the
// ball through serve, wall bounces, a paddle hit, a miss and the miss timeout,
// then a hand sequence covers reset coincident with a vsync rise.
module tb_ball_controller;
   import ball_controller_pkg::*;

   logic pixel_clock = 1'b0;
   logic reset       = 1'b1;

   ball_controller_if bus ();

   ball_controller dut (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .bus         (bus)
   );

   always #5 pixel_clock = ~pixel_clock;

   int checks = 0;
   int errors = 0;
   int b_at, b_after;

   typedef struct {
      logic serve;
      int   px, py, ticks;
      int   x, y, st, hit, miss, b;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // vsync high for one cycle, then low; samples bounce on the cycle after
   // the tick and again one cycle later.
   task automatic do_tick(output int bat, output int baft);
      @(negedge pixel_clock);
      bus.vertical_sync = 1'b1;
      @(negedge pixel_clock);
      bat = int'(bus.bounce);
      bus.vertical_sync = 1'b0;
      @(negedge pixel_clock);
      baft = int'(bus.bounce);
   endtask

   task automatic check_ball(input string tag, input int x, input int y, input int st);
      check({tag, " ball_x"}, int'(bus.ball_x), x);
      check({tag, " ball_y"}, int'(bus.ball_y), y);
      check({tag, " state"},  int'(bus.ball_state), st);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        serve  px   py    ticks  x     y    st hit miss b
      vecs[0]  = '{1'b1, 60, 2000,   1,  640,  400, 1, 0, 0, 0};
      vecs[1]  = '{1'b1, 60, 2000,   1,  644,  403, 1, 0, 0, 0};
      vecs[2]  = '{1'b1, 60, 2000, 112, 1092,  739, 1, 0, 0, 0};
      vecs[3]  = '{1'b0, 60, 2000,   1, 1096,  740, 1, 0, 0, 1};
      vecs[4]  = '{1'b0, 60, 2000,   1, 1100,  737, 1, 0, 0, 0};
      vecs[5]  = '{1'b0, 60,  331, 313,   92,  321, 1, 0, 0, 0};
      vecs[6]  = '{1'b0, 60,  331,   1,   90,  324, 1, 1, 0, 1};
      vecs[7]  = '{1'b0, 60, 2000, 573,   60,  681, 1, 1, 0, 0};
      vecs[8]  = '{1'b0, 60, 2000,   1,   60,  684, 2, 1, 1, 0};
      vecs[9]  = '{1'b1, 60, 2000,  59,   60,  684, 2, 1, 1, 0};
      vecs[10] = '{1'b0, 60, 2000,   1,  640,  400, 0, 1, 1, 0};
      vecs[11] = '{1'b0, 60, 2000,   3,  640,  400, 0, 1, 1, 0};

      bus.vertical_sync = 1'b0;
      bus.serve         = 1'b0;
      bus.paddle_x      = 16'd60;
      bus.paddle_y      = 16'd2000;
      reset             = 1'b1;
      repeat (2) @(negedge pixel_clock);
      check_ball("reset", 640, 400, 0);
      check("reset hit_count",  int'(bus.hit_count), 0);
      check("reset miss_count", int'(bus.miss_count), 0);
      check("reset bounce",     int'(bus.bounce), 0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         bus.serve    = vecs[i].serve;
         bus.paddle_x = 16'(vecs[i].px);
         bus.paddle_y = 16'(vecs[i].py);
         for (int k = 0; k < vecs[i].ticks; k++) do_tick(b_at, b_after);
         check_ball(tag, vecs[i].x, vecs[i].y, vecs[i].st);
         check({tag, " hit_count"},    int'(bus.hit_count),  vecs[i].hit);
         check({tag, " miss_count"},   int'(bus.miss_count), vecs[i].miss);
         check({tag, " bounce"},       b_at,    vecs[i].b);
         check({tag, " bounce_after"}, b_after, 0);
      end

      // Reset landing on the same edge as a vsync rise, vsync held high
      // through release with serve asserted: no tick until the next rise.
      bus.serve = 1'b1;
      do_tick(b_at, b_after);
      check_ball("rst6 serve", 640, 400, 1);
      do_tick(b_at, b_after);
      check_ball("rst6 move", 644, 403, 1);
      @(negedge pixel_clock);
      bus.vertical_sync = 1'b1;
      reset             = 1'b1;
      @(negedge pixel_clock);
      check_ball("rst6 during", 640, 400, 0);
      check("rst6 hit_count",  int'(bus.hit_count), 0);
      check("rst6 miss_count", int'(bus.miss_count), 0);
      check("rst6 bounce",     int'(bus.bounce), 0);
      reset = 1'b0;
      repeat (3) @(negedge pixel_clock);
      check_ball("rst6 vsync held", 640, 400, 0);
      bus.vertical_sync = 1'b0;
      do_tick(b_at, b_after);
      check_ball("rst6 next rise", 640, 400, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
